// File: rtl/carregador_programa.sv
// Program loader and run supervisor: streams instruction words into a 64-word
// instruction memory while holding the processor in reset, then releases it and counts Done pulses.
module carregador_programa #(
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [6:0]        i_len,
  input  logic [15:0]       i_word_in,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [15:0]       o_mem_data,
  output logic              o_mem_wren,
  output logic              o_proc_resetn,
  output logic              o_run,
  input  logic              i_done,
  output logic              o_loaded,
  output logic              o_error,
  output logic [15:0]       o_instr_count
);

  localparam logic [7:0] LP_DEPTH = 8'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [6:0]        r_len;
  logic [6:0]        r_ptr;
  logic              r_mem_wren;
  logic [ADDR_W-1:0] r_mem_address;
  logic [15:0]       r_mem_data;
  logic              r_error;
  logic [15:0]       r_instr_count;

  logic       w_len_legal;
  logic       w_accept;
  logic [6:0] w_ptr_next;
  logic       w_last_word;
  logic       w_load_start;
  logic       w_len_bad;

  assign w_len_legal = (i_len != 7'd0) && ({1'b0, i_len} <= LP_DEPTH);
  assign w_accept    = (r_state == S_LOAD) && i_word_valid;
  assign w_ptr_next  = r_ptr + 7'd1;
  assign w_last_word = (w_ptr_next == r_len);

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Start is only honoured when no load is in flight (IDLE or RUN).
  always_comb begin
    w_next_state = r_state;
    w_load_start = 1'b0;
    w_len_bad    = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (i_start) begin
          if (w_len_legal) begin
            w_next_state = S_LOAD;
            w_load_start = 1'b1;
          end else begin
            w_len_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_word) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH:   w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_RUN;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= 16'd0;
      r_ptr         <= 7'd0;
    end else begin
      r_mem_wren <= w_accept;
      if (w_load_start) begin
        r_ptr <= 7'd0;
      end else if (w_accept) begin
        r_mem_address <= r_ptr[ADDR_W-1:0];
        r_mem_data    <= i_word_in;
        r_ptr         <= w_ptr_next;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_len   <= 7'd0;
      r_error <= 1'b0;
    end else begin
      if (w_load_start) begin
        r_len   <= i_len;
        r_error <= 1'b0;
      end else if (w_len_bad) begin
        r_error <= 1'b1;
      end
    end
  end

  // Cleared on the way into RELEASE so it reads zero for the whole release cycle.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_instr_count <= 16'd0;
    end else begin
      if (r_state == S_FLUSH) begin
        r_instr_count <= 16'd0;
      end else if ((r_state == S_RUN) && i_done && (r_instr_count != 16'hFFFF)) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign o_word_ready  = (r_state == S_LOAD);
  assign o_proc_resetn = (r_state == S_RELEASE) || (r_state == S_RUN);
  assign o_run         = (r_state == S_RUN);
  assign o_loaded      = (r_state == S_RELEASE) || (r_state == S_RUN);
  assign o_mem_wren    = r_mem_wren;
  assign o_mem_address = r_mem_address;
  assign o_mem_data    = r_mem_data;
  assign o_error       = r_error;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: directed scenarios plus random
// traffic, all compared every cycle against a phase-counting behavioural model.
module tb_carregador_programa;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  len = 7'd0;
  logic [15:0] wordIn = 16'd0;
  logic        wordValid = 1'b0;
  logic        done = 1'b0;

  logic        wordReady;
  logic [5:0]  memAddress;
  logic [15:0] memData;
  logic        memWren;
  logic        procResetn;
  logic        run;
  logic        loaded;
  logic        error;
  logic [15:0] instrCount;

  carregador_programa #(.MEM_DEPTH(64), .ADDR_W(6)) dut (
    .i_clock       (clock),
    .i_resetn      (resetn),
    .i_start       (start),
    .i_len         (len),
    .i_word_in     (wordIn),
    .i_word_valid  (wordValid),
    .o_word_ready  (wordReady),
    .o_mem_address (memAddress),
    .o_mem_data    (memData),
    .o_mem_wren    (memWren),
    .o_proc_resetn (procResetn),
    .o_run         (run),
    .i_done        (done),
    .o_loaded      (loaded),
    .o_error       (error),
    .o_instr_count (instrCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  bit cmpOn = 1'b0;

  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Model: mSince counts cycles since the last word landed (1 = flush,
  // 2 = release, 3+ = running); 0 means idle or loading.
  bit mLoading = 1'b0;
  int mRemaining = 0;
  int mNextAddr = 0;
  int mSince = 0;
  int mCount = 0;
  bit mError = 1'b0;
  bit mWren = 1'b0;
  int mAddr = 0;
  int mData = 0;
  int oldSince;
  bit legal;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mLoading = 1'b0; mRemaining = 0; mNextAddr = 0; mSince = 0;
      mCount = 0; mError = 1'b0; mWren = 1'b0; mAddr = 0; mData = 0;
    end else begin
      legal = (int'(len) >= 1) && (int'(len) <= 64);
      oldSince = mSince;
      mWren = 1'b0;
      if (mLoading) begin
        if (wordValid) begin
          mWren = 1'b1;
          mAddr = mNextAddr;
          mData = int'(wordIn);
          mNextAddr++;
          mRemaining--;
          if (mRemaining == 0) begin
            mLoading = 1'b0;
            mSince = 1;
          end
        end
      end else if (start && (oldSince == 0 || oldSince >= 3)) begin
        if (legal) begin
          mLoading = 1'b1; mRemaining = int'(len); mNextAddr = 0; mError = 1'b0; mSince = 0;
        end else begin
          mError = 1'b1;
        end
      end
      if (oldSince >= 3 && done && mCount < 65535) mCount++;
      if (oldSince == 1) mCount = 0;
      if (mSince == oldSince && oldSince >= 1 && oldSince < 3) mSince = oldSince + 1;
    end
  end

  always @(negedge clock) begin
    if (cmpOn) begin
      checkOutput("word_ready", 32'(wordReady), 32'(mLoading));
      checkOutput("mem_wren", 32'(memWren), 32'(mWren));
      checkOutput("proc_resetn", 32'(procResetn), 32'(mSince >= 2));
      checkOutput("run", 32'(run), 32'(mSince >= 3));
      checkOutput("loaded", 32'(loaded), 32'(mSince >= 2));
      checkOutput("error", 32'(error), 32'(mError));
      checkOutput("instr_count", 32'(instrCount), 32'(mCount));
      if (mWren) begin
        checkOutput("mem_address", 32'(memAddress), 32'(mAddr));
        checkOutput("mem_data", 32'(memData), 32'(mData));
      end
    end
  end

  typedef struct {int cyc; int addr; int data;} wrRec_t;
  wrRec_t wrLog[$];
  int prRise = -1;
  int runRise = -1;
  bit prevPr = 1'b0;
  bit prevRun = 1'b0;

  always @(negedge clock) begin
    if (memWren === 1'b1) wrLog.push_back('{cycle, int'(memAddress), int'(memData)});
    if (procResetn === 1'b1 && !prevPr) prRise = cycle;
    if (run === 1'b1 && !prevRun) runRise = cycle;
    prevPr = (procResetn === 1'b1);
    prevRun = (run === 1'b1);
  end

  task automatic applyStimulus(input logic st, input logic [6:0] ln, input logic v,
                               input logic [15:0] w, input logic d);
    @(posedge clock);
    #2;
    start = st; len = ln; wordValid = v; wordIn = w; done = d;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #2;
    resetn = 1'b0;
    start = 1'b0; len = 7'd0; wordValid = 1'b0; wordIn = 16'd0; done = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    resetn = 1'b1;
    wrLog.delete();
    prRise = -1;
    runRise = -1;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  int lastHs;
  int badAddr;

  initial begin
    doReset();
    cmpOn = 1'b1;
    @(negedge clock);
    checkOutput("reset_proc_resetn", 32'(procResetn), 32'd0);
    checkOutput("reset_count", 32'(instrCount), 32'd0);
    checkOutput("reset_address", 32'(memAddress), 32'd0);

    // Three back-to-back words.
    applyStimulus(1'b1, 7'd3, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h0048, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h0049, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h004A, 1'b0);
    lastHs = cycle;
    idleCycles(6);
    checkOutput("len3_write_count", 32'(wrLog.size()), 32'd3);
    if (wrLog.size() == 3) begin
      checkOutput("len3_addr0", 32'(wrLog[0].addr), 32'd0);
      checkOutput("len3_data0", 32'(wrLog[0].data), 32'h0048);
      checkOutput("len3_addr2", 32'(wrLog[2].addr), 32'd2);
      checkOutput("len3_data2", 32'(wrLog[2].data), 32'h004A);
      checkOutput("len3_last_write_cycle", 32'(wrLog[2].cyc - lastHs), 32'd1);
    end
    checkOutput("len3_proc_resetn_rise", 32'(prRise - lastHs), 32'd2);
    checkOutput("len3_run_rise", 32'(runRise - lastHs), 32'd3);

    // Len = 64 with Word_valid every other cycle; extra valids after the last word.
    doReset();
    applyStimulus(1'b1, 7'd64, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 132; i++)
      applyStimulus(1'b0, 7'd0, (i % 2) == 0, 16'($urandom), 1'b0);
    idleCycles(2);
    checkOutput("len64_write_count", 32'(wrLog.size()), 32'd64);
    badAddr = 0;
    foreach (wrLog[i]) if (wrLog[i].addr != i) badAddr++;
    checkOutput("len64_addr_sequence", 32'(badAddr), 32'd0);
    @(negedge clock);
    checkOutput("len64_loaded", 32'(loaded), 32'd1);

    // Illegal lengths then a legal one.
    doReset();
    applyStimulus(1'b1, 7'd0, 1'b0, 16'd0, 1'b0);
    idleCycles(1);
    @(negedge clock);
    checkOutput("len0_error", 32'(error), 32'd1);
    checkOutput("len0_ready", 32'(wordReady), 32'd0);
    applyStimulus(1'b1, 7'd65, 1'b0, 16'd0, 1'b0);
    idleCycles(1);
    @(negedge clock);
    checkOutput("len65_error", 32'(error), 32'd1);
    checkOutput("len65_ready", 32'(wordReady), 32'd0);
    applyStimulus(1'b1, 7'd1, 1'b0, 16'd0, 1'b0);
    idleCycles(1);
    @(negedge clock);
    checkOutput("len1_error_cleared", 32'(error), 32'd0);
    checkOutput("len1_ready", 32'(wordReady), 32'd1);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h1234, 1'b0);
    idleCycles(4);

    // Five Done pulses, then a legal Start aborts the run.
    doReset();
    applyStimulus(1'b1, 7'd2, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h5555, 1'b0);
    idleCycles(4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 7'd0, 1'b0, 16'd0, 1'b1);
      applyStimulus(1'b0, 7'd0, 1'b0, 16'd0, 1'b0);
    end
    idleCycles(1);
    @(negedge clock);
    checkOutput("done5_count", 32'(instrCount), 32'd5);
    applyStimulus(1'b1, 7'd3, 1'b0, 16'd0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_run", 32'(run), 32'd0);
    checkOutput("abort_proc_resetn", 32'(procResetn), 32'd0);
    checkOutput("abort_ready", 32'(wordReady), 32'd1);
    checkOutput("abort_count_holds", 32'(instrCount), 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'd0, 1'b1, 16'(i), 1'b0);
    idleCycles(4);

    // Asynchronous reset after two of four words.
    doReset();
    applyStimulus(1'b1, 7'd4, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'hCAFE, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b0, 16'd0, 1'b0);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("areset_ready", 32'(wordReady), 32'd0);
    checkOutput("areset_wren", 32'(memWren), 32'd0);
    checkOutput("areset_address", 32'(memAddress), 32'd0);
    checkOutput("areset_data", 32'(memData), 32'd0);
    checkOutput("areset_proc_resetn", 32'(procResetn), 32'd0);
    checkOutput("areset_run", 32'(run), 32'd0);
    checkOutput("areset_loaded", 32'(loaded), 32'd0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h2222, 1'b0);
    idleCycles(3);
    checkOutput("areset_write_count", 32'(wrLog.size()), 32'd2);

    // Random traffic, including illegal lengths and Start at any time.
    doReset();
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom % 30) == 0, 7'($urandom % 70), ($urandom % 4) != 0,
                    16'($urandom), 1'($urandom % 2));
    idleCycles(2);

    // Saturation of the instruction counter.
    doReset();
    applyStimulus(1'b1, 7'd1, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 16'h7777, 1'b0);
    idleCycles(3);
    for (int i = 0; i < 65540; i++) applyStimulus(1'b0, 7'd0, 1'b0, 16'd0, 1'b1);
    idleCycles(1);
    @(negedge clock);
    checkOutput("count_saturated", 32'(instrCount), 32'h0000FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader and run supervisor sitting in front of the multicycle processor's 64-word instruction memory. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into consecutive addresses starting at 0. While loading, it holds the processor in reset. Afterwards it releases the processor, asserts `Run`, and counts completed instructions from the processor's `Done` pulses.

## Interface
- `MEM_DEPTH`, default 64: instruction memory words. Legal lengths are 1..MEM_DEPTH.
- `ADDR_W`, default 6: instruction memory address width.
- `Clock`, input, 1: single clock. Everything updates on its rising edge.
- `Resetn`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: one-cycle request to begin a load of `Len` words.
- `Len`, input, 7: number of words to load. Sampled only when `Start` is accepted.
- `Word_in`, input, 16: instruction word from the host.
- `Word_valid`, input, 1: `Word_in` is valid.
- `Word_ready`, output, 1: loader can accept a word this cycle.
- `Mem_address`, output, ADDR_W: instruction memory write address.
- `Mem_data`, output, 16: instruction memory write data.
- `Mem_wren`, output, 1: instruction memory write enable.
- `Proc_Resetn`, output, 1: active-low reset to the processor.
- `Run`, output, 1: processor `Run` input.
- `Done`, input, 1: processor `Done` pulse, one per completed instruction.
- `Loaded`, output, 1: a program has been fully written and the processor is released.
- `Error`, output, 1: sticky flag for an illegal `Len`.
- `Instr_count`, output, 16: instructions completed since release, saturating.

## Operation
- States are IDLE, LOAD, FLUSH, RELEASE and RUN. Reset enters IDLE.
- **IDLE**
  - Outputs: `Proc_Resetn`=0, `Run`=0, `Word_ready`=0.
  - `Start` with 1 ≤ `Len` ≤ 64:
    - latch `Len`, clear the write pointer, clear `Error`;
    - go to LOAD.
  - `Start` with `Len`=0 or `Len`>64: set `Error`=1 and stay in IDLE.
- **LOAD**
  - Outputs: `Word_ready`=1, `Proc_Resetn`=0.
  - A word is accepted on any cycle where `Word_valid` and `Word_ready` are both 1.
  - On the edge after an accepted word:
    - `Mem_wren`=1, `Mem_address`=pointer, `Mem_data`=`Word_in`, each for exactly one cycle;
    - the pointer increments.
  - When the accepted word is number `Len`, go to FLUSH. `Word_ready` is 0 from FLUSH onward.
  - `Start` is ignored in LOAD.
- **FLUSH**
  - Lasts one cycle, so the final registered write completes.
  - Then go to RELEASE.
- **RELEASE**
  - Lasts one cycle.
  - Outputs: `Proc_Resetn`=1, `Run`=0, `Loaded`=1, `Instr_count` cleared.
  - Then go to RUN.
- **RUN**
  - Outputs: `Proc_Resetn`=1, `Run`=1, `Loaded`=1.
  - Each cycle with `Done`=1 increments `Instr_count`. The count saturates at 16'hFFFF.
  - `Start` with a legal `Len`:
    - aborts execution and goes to LOAD;
    - `Proc_Resetn`=0, `Run`=0 and `Loaded`=0 from the next cycle;
    - `Instr_count` holds until the next RELEASE.
  - `Start` with an illegal `Len`: set `Error`=1 and stay in RUN.
- Words are never written past address `Len`-1. The pointer never wraps inside a load.
- `Mem_wren` is never 1 outside the cycle after an accepted word.

## Timing
- Reset values:
  - state IDLE;
  - `Word_ready`=0, `Mem_wren`=0, `Mem_address`=0, `Mem_data`=0;
  - `Proc_Resetn`=0, `Run`=0, `Loaded`=0, `Error`=0, `Instr_count`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from `Word_valid`, `Start` or `Done` to any output.
- Cycle sequence:
  - `Start` sampled at edge k: `Word_ready`=1 from k+1.
  - Word accepted at edge j: write presented during cycle j+1.
  - Last word accepted at edge n:
    - FLUSH in cycle n+1;
    - RELEASE in cycle n+2, with `Proc_Resetn` rising at edge n+2;
    - `Run` rising at edge n+3.
- Back-to-back `Word_valid` sustains one word per cycle. `Len` words take at least `Len` cycles.
- Asynchronous `Resetn` assertion mid-load or mid-run:
  - immediately forces all reset values, including `Proc_Resetn`=0;
  - partial memory contents are left as written.
- `Done` arriving in RELEASE is not counted. Only RUN counts.

## Test plan
- Reset, `Start` with `Len`=3, words 16'h0048/0049/004A sent back-to-back:
  - three `Mem_wren` pulses at addresses 0, 1 and 2 carrying those words;
  - `Proc_Resetn` rises 2 cycles after the third accept, and `Run` 1 cycle later.
- `Len`=64 with `Word_valid` toggled every other cycle:
  - 64 writes to addresses 0..63, no write to a 65th address;
  - `Loaded`=1 after FLUSH and RELEASE.
- `Start` with `Len`=0, then with `Len`=65:
  - `Error`=1, state stays IDLE, `Word_ready`=0;
  - a following `Start` with `Len`=1 clears `Error`.
- In RUN, 5 `Done` pulses give `Instr_count`=5. A legal `Start` then gives `Run`=0 and `Proc_Resetn`=0 the next cycle and `Word_ready`=1.
- `Resetn` pulsed low after 2 of 4 words:
  - all outputs return to reset values asynchronously;
  - the remaining words are not written.
- `Instr_count` preset near saturation, for example through 65540 `Done` pulses: the count holds at 16'hFFFF.
